// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner.
//   cnt_width()  : counter width for a count that must reach max_val
//                  ($clog2(max_val+1)), clamped to 1..32 bits.
//   DEB_10MS, LONG_500MS, RPT_100MS : timing presets for a 125 MHz sysclk.
package btn_pkg;

    localparam int DEB_10MS   = 1_250_000;
    localparam int LONG_500MS = 62_500_000;
    localparam int RPT_100MS  = 12_500_000;

    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1)  w = 1;
        if (w > 32) w = 32;
        return w;
    endfunction

endpackage

// File: rtl/btn_cond_chan.sv
// One button channel: 2-FF synchroniser, counter debounce, press/release
// edge pulses, long-press pulse and auto-repeat pulses while held.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   btn_i          raw pin, already polarity-corrected (1 = pressed)
//   level_o        debounced level
//   press_o        1-cycle pulse on debounced rise
//   release_o      1-cycle pulse on debounced fall
//   long_o         1-cycle pulse LONG_CYCLES after the rise
//   rpt_o          1-cycle pulse every REPEAT_CYCLES after long_o while held
module btn_cond_chan
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic rpt_o
);

    localparam int DW = cnt_width(DEB_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          press_q, press_d, rel_q, rel_d;
    logic          long_q, long_d, rpt_q, rpt_d;
    logic          flip, held;

    always_comb begin
        s1_d   = btn_i;
        s2_d   = s1_q;
        lvl_d  = lvl_q;
        dcnt_d = dcnt_q;
        flip   = 1'b0;

        if (s2_q == lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            flip   = 1'b1;
            lvl_d  = ~lvl_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        press_d = flip & ~lvl_q;
        rel_d   = flip & lvl_q;

        // Level was 1 before this edge and is not falling at it: the only
        // case in which hold/repeat may advance. The rising flip edge and
        // the falling flip edge both leave the counters at zero.
        held   = lvl_q & ~flip;
        hcnt_d = '0;
        rcnt_d = '0;
        long_d = 1'b0;
        rpt_d  = 1'b0;

        if (held) begin
            hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + HW'(1);
            rcnt_d = rcnt_q;
            if (hcnt_q == LONG_LAST) begin
                long_d = 1'b1;
                rcnt_d = '0;
            end else if (REPEAT_CYCLES > 0 && hcnt_q == HOLD_MAX) begin
                // Saturated hold counter means long_o already fired.
                if (rcnt_q == RPT_LAST) begin
                    rpt_d  = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            rcnt_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            lvl_q   <= lvl_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            rcnt_q  <= rcnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign level_o   = lvl_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;
    assign rpt_o     = rpt_q;

endmodule

// File: rtl/btn_cond_array.sv
// N-channel push-button conditioner. Applies the pin polarity, then runs
// one independent btn_cond_chan per channel. All outputs are registered
// and active-high regardless of pin polarity.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   btn_i          raw asynchronous button pins [N_CH]
//   level_o        debounced levels
//   press_o / release_o   1-cycle edge pulses
//   long_o / rpt_o        long-press and auto-repeat pulses
module btn_cond_array
    import btn_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_o,
    output logic [N_CH-1:0] rpt_o
);

    logic [N_CH-1:0] btn_pol;

    assign btn_pol = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        btn_cond_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .btn_i    (btn_pol[g]),
            .level_o  (level_o[g]),
            .press_o  (press_o[g]),
            .release_o(release_o[g]),
            .long_o   (long_o[g]),
            .rpt_o    (rpt_o[g])
        );
    end

endmodule
